// File: rtl/hcsr04_sequencer.sv
// Single-channel HC-SR04 ranging sequencer: trigger, echo timing with timeouts, echo width to BCD mm; `MEAS_BIN_EN adds a binary mm output.
// Latency: echo is seen 2 clk late (2-flop sync), valid follows the synchronised falling edge by one cycle; start is dropped (not queued) while busy.
module hcsr04_sequencer #(
    parameter int TICK_DIV   = 1,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int PERIOD_US  = 60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        auto_en,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic [15:0] dist_bcd,
    output logic        valid,
    output logic        timeout,
    output logic        ovf
`ifdef MEAS_BIN_EN
    ,
    output logic [13:0] dist_mm
`endif
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [31:0]   TRIG_LAST = 32'(TRIG_US - 1);
    localparam logic [31:0]   TMO_LAST  = 32'(TIMEOUT_US - 1);
    localparam logic [31:0]   PERIOD_N  = 32'(PERIOD_US);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TRIG = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_MEAS = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_FAIL = 3'd5;
    localparam logic [2:0] ST_HOLD = 3'd6;

    logic [2:0]    state_q, state_d;
    logic          echo_s1_q, echo_s2_q, echo_prev_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [31:0]   tmr_q, tmr_d;
    logic [31:0]   period_q, period_d;
    logic [2:0]    pre_cnt_q, pre_cnt_d;
    logic [2:0]    pre_ph_q, pre_ph_d;
    logic [2:0]    step_last;
    logic [15:0]   bcd_q, bcd_d;
    logic [15:0]   dist_q, dist_d;
    logic          sat_q, sat_d;
    logic          to_q, to_d;
    logic          ovf_q, ovf_d;
`ifdef MEAS_BIN_EN
    logic [13:0]   mm_q, mm_d;
    logic [13:0]   dist_mm_q, dist_mm_d;
`endif
    logic          tick, rise, fall, tmo_hit, period_done;
    logic          enter_trig, enter_meas, mm_step;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        rise        = echo_s2_q & ~echo_prev_q;
        fall        = ~echo_s2_q & echo_prev_q;
        tick        = (state_q != ST_IDLE) && (tick_cnt_q == TICK_LAST);
        tmo_hit     = tick && (tmr_q == TMO_LAST);
        period_done = (period_q >= PERIOD_N) || (tick && (period_q == PERIOD_N - 32'd1));

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start || auto_en) state_d = ST_TRIG;
            ST_TRIG: if (tick && (tmr_q == TRIG_LAST)) state_d = ST_WAIT;
            ST_WAIT: begin
                if (rise)         state_d = ST_MEAS;
                else if (tmo_hit) state_d = ST_FAIL;
            end
            // a falling edge coinciding with the timeout still counts as a result
            ST_MEAS: begin
                if (fall)         state_d = ST_DONE;
                else if (tmo_hit) state_d = ST_FAIL;
            end
            ST_DONE, ST_FAIL: state_d = ST_HOLD;
            ST_HOLD: if (period_done) state_d = auto_en ? ST_TRIG : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        enter_trig = (state_d == ST_TRIG) && (state_q != ST_TRIG);
        enter_meas = (state_d == ST_MEAS) && (state_q != ST_MEAS);

        if (enter_trig || (state_q == ST_IDLE) || tick) tick_cnt_d = '0;
        else                                            tick_cnt_d = tick_cnt_q + TW'(1);

        if (state_d != state_q) tmr_d = '0;
        else if (tick)          tmr_d = tmr_q + 32'd1;
        else                    tmr_d = tmr_q;

        if (enter_trig)                          period_d = '0;
        else if (tick && (period_q < PERIOD_N))  period_d = period_q + 32'd1;
        else                                     period_d = period_q;

        // 6,6,6,6,5 ticks per mm step: 29 us of echo = 5 mm
        step_last = (pre_ph_q == 3'd4) ? 3'd4 : 3'd5;
        mm_step   = 1'b0;
        pre_cnt_d = pre_cnt_q;
        pre_ph_d  = pre_ph_q;
        bcd_d     = bcd_q;
        sat_d     = sat_q;
`ifdef MEAS_BIN_EN
        mm_d      = mm_q;
`endif
        if (enter_meas) begin
            pre_cnt_d = '0;
            pre_ph_d  = '0;
            bcd_d     = '0;
            sat_d     = 1'b0;
`ifdef MEAS_BIN_EN
            mm_d      = '0;
`endif
        end else if ((state_q == ST_MEAS) && tick) begin
            if (pre_cnt_q == step_last) begin
                mm_step   = 1'b1;
                pre_cnt_d = '0;
                pre_ph_d  = (pre_ph_q == 3'd4) ? 3'd0 : pre_ph_q + 3'd1;
            end else begin
                pre_cnt_d = pre_cnt_q + 3'd1;
            end
        end

        if (mm_step) begin
            if (bcd_q == 16'h9999) sat_d = 1'b1;
            else                   bcd_d = bcd_inc(bcd_q);
`ifdef MEAS_BIN_EN
            if (mm_q != 14'd9999)  mm_d  = mm_q + 14'd1;
`endif
        end

        dist_d = dist_q;
        to_d   = to_q;
        ovf_d  = ovf_q;
`ifdef MEAS_BIN_EN
        dist_mm_d = dist_mm_q;
`endif
        // results are latched on entry so they are already stable while valid is high
        if ((state_q == ST_MEAS) && (state_d == ST_DONE)) begin
            dist_d = bcd_d;
            ovf_d  = sat_d;
            to_d   = 1'b0;
`ifdef MEAS_BIN_EN
            dist_mm_d = mm_d;
`endif
        end else if ((state_d == ST_FAIL) && (state_q != ST_FAIL)) begin
            to_d  = 1'b1;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            echo_s1_q   <= 1'b0;
            echo_s2_q   <= 1'b0;
            echo_prev_q <= 1'b0;
            tick_cnt_q  <= '0;
            tmr_q       <= '0;
            period_q    <= '0;
            pre_cnt_q   <= '0;
            pre_ph_q    <= '0;
            bcd_q       <= '0;
            sat_q       <= 1'b0;
            dist_q      <= '0;
            to_q        <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef MEAS_BIN_EN
            mm_q        <= '0;
            dist_mm_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            echo_s1_q   <= echo;
            echo_s2_q   <= echo_s1_q;
            echo_prev_q <= echo_s2_q;
            tick_cnt_q  <= tick_cnt_d;
            tmr_q       <= tmr_d;
            period_q    <= period_d;
            pre_cnt_q   <= pre_cnt_d;
            pre_ph_q    <= pre_ph_d;
            bcd_q       <= bcd_d;
            sat_q       <= sat_d;
            dist_q      <= dist_d;
            to_q        <= to_d;
            ovf_q       <= ovf_d;
`ifdef MEAS_BIN_EN
            mm_q        <= mm_d;
            dist_mm_q   <= dist_mm_d;
`endif
        end
    end

    assign trig     = (state_q == ST_TRIG);
    assign busy     = (state_q != ST_IDLE);
    assign valid    = (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign dist_bcd = dist_q;
    assign timeout  = to_q;
    assign ovf      = ovf_q;
`ifdef MEAS_BIN_EN
    assign dist_mm  = dist_mm_q;
`endif

endmodule

// File: doc/hcsr04_sequencer.md
Name: hcsr04_sequencer

Overview:
Sequences one ultrasonic ranging channel: issues the trigger pulse, times the echo with timeouts, and converts echo width to distance in millimetres (4-digit BCD, shown as XXX.X cm). Supports single-shot and free-running auto modes. Sits between the divided clock domain and the save/switch/7-segment path, and replaces the ad-hoc free-running trigger.

Parameters:
TICK_DIV, 1, clk cycles per 1 µs tick (1 = 1 MHz clk)
TRIG_US, 10, trigger pulse width in µs
TIMEOUT_US, 30000, max wait for echo rise, and max echo-high width, in µs
PERIOD_US, 60000, minimum trigger-to-trigger spacing in µs

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request for one measurement
auto_en  in  1  1 = re-trigger every PERIOD_US
echo  in  1  asynchronous echo from sensor
trig  out  1  trigger to sensor
busy  out  1  high in any state except IDLE
dist_bcd  out  16  last distance, BCD mm {d3,d2,d1,d0}
valid  out  1  1-cycle pulse when dist_bcd or timeout is updated
timeout  out  1  sticky flag, last measurement failed
ovf  out  1  last result saturated at 9999

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: trig=0, busy=0, dist_bcd=0x0000, valid=0, timeout=0, ovf=0. State is IDLE; all counters and synchronisers are cleared.
- echo passes through a 2-flop synchroniser, so there is 2 cycles of latency. All echo edges are detected on the synchronised signal.
- Tick generator: a µs tick is asserted every TICK_DIV clk cycles. It runs freely outside IDLE and restarts at phase 0 on entry to TRIG.
- State machine:
  - IDLE: exit to TRIG when start=1 or auto_en=1.
  - TRIG: trig=1 for exactly TRIG_US ticks, then go to WAIT_RISE.
  - WAIT_RISE: go to MEASURE on the echo rising edge. Go to FAIL after TIMEOUT_US ticks.
  - MEASURE: count the echo-high width. Go to DONE on the echo falling edge. Go to FAIL after TIMEOUT_US ticks.
  - DONE: load dist_bcd, set timeout=0, pulse valid, go to HOLDOFF.
  - FAIL: dist_bcd is unchanged, set timeout=1, set ovf=0, pulse valid, go to HOLDOFF.
  - HOLDOFF: wait until PERIOD_US ticks have elapsed since entry to TRIG. Then go to TRIG if auto_en=1, otherwise go to IDLE.
- Distance conversion: mm = echo_µs / 5.8, truncated.
  - A fractional prescaler emits an mm-step after 6,6,6,6,5 ticks, repeating (29 µs = 5 mm).
  - The prescaler phase and the BCD counter are cleared on entry to MEASURE.
  - The BCD counter is 4 digits with decimal carry on each mm-step.
  - At 9999 the counter holds and ovf is set in DONE.
- start is ignored while busy=1; requests are not queued.
- Dropping auto_en mid-measurement completes the current measurement, then returns to IDLE.
- An echo already high on entry to WAIT_RISE does not count as a rising edge; a true low-to-high transition is required.
- Echo falling and timeout in the same cycle: the falling edge wins and the result goes to DONE.
- rst asserted in any state aborts immediately. trig drops the same cycle the reset is sampled.

Optional Feature:
MEAS_BIN_EN
- Defined: adds output port dist_mm[13:0], a binary mm count updated together with dist_bcd and saturating at 9999.
- Not defined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset mid-TRIG → trig=0 next cycle, busy=0, dist_bcd=0x0000, timeout=0.
- TICK_DIV=1, start pulse, echo high 580 µs → trig high exactly 10 cycles; valid pulses once; dist_bcd=0x0100, timeout=0, ovf=0.
- Echo high 28 µs → dist_bcd=0x0004. Echo high 29 µs → dist_bcd=0x0005.
- No echo rise → valid at 10+30000 ticks after trig rise; timeout=1; dist_bcd keeps its previous value.
- Echo held high beyond 30000 µs → FAIL path taken.
- Echo high 58 ms with TIMEOUT_US raised to 60000 → dist_bcd=0x9999, ovf=1.
- auto_en=1 held → trig rising edges exactly 60000 cycles apart. start during busy → no extra trig.
- Clear auto_en mid-MEASURE → the result is delivered, then busy=0.
